weight_fetch_control_unit: RTL
==============================

Name: weight_fetch_control_unit

Overview:
- Sequences weight-tile transfers from weight memory into the double-buffered weight registers of the systolic array.
- Produces the compute_weights_rdy / compute_weights_buffered handshake used by the compute controller, and consumes its next_weight_tile pulse to release buffer slots.
- Tiles are fetched in compute order: y (H) inner, x (W) outer.

Parameters:
MUL_SIZE, 32, array dimension; rows per tile and tile pitch in weight memory
WADDR_W, 14, weight memory address width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
start_i  in  1  pulse; latches dims/addr and begins a layer
H_DIM_i  in  9  layer height minus 1; tiles_y = (H_DIM_i>>5)+1
W_DIM_i  in  9  layer width minus 1; tiles_x = (W_DIM_i>>5)+1
weight_start_addr_i  in  WADDR_W  base address of tile 0 row 0
next_weight_tile_i  in  1  pulse from compute controller; active tile consumed
weight_mem_rd_en_o  out  1  weight memory read strobe
weight_mem_addr_o  out  WADDR_W  read address
weight_buf_wr_en_o  out  1  write returned row into weight buffer (memory latency fixed at 1)
weight_buf_wr_row_o  out  5  row index written
weight_buf_wr_sel_o  out  1  target buffer slot (LSB of tile index)
compute_weights_rdy_o  out  1  at least one complete tile is resident
compute_weights_buffered_o  out  1  two complete tiles are resident (active + next)
busy_o  out  1  layer in progress
done_o  out  1  one-cycle pulse; all tiles fetched and consumed

Behaviour:
- Reset: state IDLE; all counters 0; every output 0. Reset mid-operation abandons the layer with no done_o.
- start_i in IDLE latches inputs and computes total = tiles_x*tiles_y (max 256, 9 bits). start_i while busy_o=1 is ignored.
- Counters: fetch_tile (tiles started), row_cnt (0..31), complete (tiles fully written), consumed.
  - alloc = fetch_tile - consumed.
  - occ = complete - consumed.
- Read address = latched_base + fetch_tile*MUL_SIZE + row_cnt, truncated to WADDR_W.
- Write path: weight_buf_wr_en_o/row/sel are the read strobe/row/sel delayed 1 cycle.
- States:
  - IDLE → FETCH on start_i.
  - FETCH: assert rd_en, row_cnt++. At row_cnt==31, fetch_tile++ and row_cnt=0, then:
    - → WAIT_DONE if fetch_tile+1==total;
    - else stay in FETCH if alloc after increment < 2 (back-to-back, no bubble);
    - else → WAIT_SLOT.
  - WAIT_SLOT: no reads; → FETCH the cycle after alloc < 2.
  - WAIT_DONE: → IDLE when consumed==total and no write pending; done_o pulses on that transition, busy_o drops the same cycle.
- complete increments in the cycle row 31 is written. compute_weights_rdy_o = (occ>=1), registered; compute_weights_buffered_o = (occ==2), registered.
- Timing example: start_i at cycle 0 → reads cycles 1..32 → writes cycles 2..33 → rdy high from cycle 34.
- Simultaneous events:
  - Completion and next_weight_tile_i in the same cycle: occ unchanged; both counters update.
  - next_weight_tile_i in the cycle that alloc reaches 2: the slot is freed, and FETCH continues without entering WAIT_SLOT.
- next_weight_tile_i with occ==0, or in IDLE: ignored; counters do not underflow.

Optional Feature:
- Macro: WEIGHT_FETCH_ERR_EN.
- When defined: adds output err_o (1 bit, reset 0, sticky until rst_i). It sets on any of:
  - next_weight_tile_i with occ==0;
  - start_i while busy_o=1;
  - fetch address overflow past 2^WADDR_W.
- When undefined: no err_o port, and these conditions are silently ignored as described above.

Test Plan:
- H=31, W=31, base 0x100, start at cycle 0 → reads 0x100..0x11F on cycles 1..32; wr_row 0..31 with sel 0 on cycles 2..33; rdy=1 from cycle 34. After next_weight_tile_i: done_o pulses once, busy_o=0.
- H=63, W=31 (2 tiles), no consumption → tile 1 reads 0x120..0x13F back-to-back on cycles 33..64 with sel 1; buffered=1 from cycle 66; no further reads.
- H=95, W=63 (6 tiles), next_weight_tile_i every 40 cycles after rdy → WAIT_SLOT entered; each release restarts fetch next cycle; sel alternates 0,1,0,…; 6 tiles written; done_o after the 6th release.
- next_weight_tile_i in the same cycle as tile-1 row 31 write → occ stays 1; rdy stays 1; buffered stays 0.
- rst_i asserted mid-tile (row 17) → next cycle all outputs 0, state IDLE. A new start_i re-fetches from row 0 of the new base.
- With WEIGHT_FETCH_ERR_EN: next_weight_tile_i before first rdy → err_o=1 and stays 1. Without the macro: no effect, and counters remain 0.

Source files
------------

// File: rtl/weight_fetch_control_unit.sv
// Weight-tile fetch sequencer: streams MUL_SIZE-row tiles from weight memory into the
// double-buffered weight registers. Optional sticky error output under WEIGHT_FETCH_ERR_EN.
module weight_fetch_control_unit #(
  parameter int unsigned MUL_SIZE = 32,
  parameter int unsigned WADDR_W  = 14
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [8:0]                  H_DIM_i,
  input  logic [8:0]                  W_DIM_i,
  input  logic [WADDR_W-1:0]          weight_start_addr_i,
  input  logic                        next_weight_tile_i,
  output logic                        weight_mem_rd_en_o,
  output logic [WADDR_W-1:0]          weight_mem_addr_o,
  output logic                        weight_buf_wr_en_o,
  output logic [$clog2(MUL_SIZE)-1:0] weight_buf_wr_row_o,
  output logic                        weight_buf_wr_sel_o,
  output logic                        compute_weights_rdy_o,
  output logic                        compute_weights_buffered_o,
  output logic                        busy_o,
  output logic                        done_o
`ifdef WEIGHT_FETCH_ERR_EN
  ,
  output logic                        err_o
`endif
);

  localparam int unsigned ROW_W  = $clog2(MUL_SIZE);
  localparam int unsigned DIM_W  = 9;
  localparam int unsigned TDIM_W = DIM_W - ROW_W + 1;
  localparam int unsigned CNT_W  = 2 * TDIM_W - 1;
  localparam int unsigned AW1    = WADDR_W + 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MUL_SIZE - 1);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT_SLOT, WAIT_DONE} state_e;

  state_e             state_q, state_d;
  logic [WADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]   total_q, total_d;
  logic [CNT_W-1:0]   fetch_tile_q, fetch_tile_d;
  logic [ROW_W-1:0]   row_cnt_q, row_cnt_d;
  logic [CNT_W-1:0]   complete_q, complete_d;
  logic [CNT_W-1:0]   consumed_q, consumed_d;
  logic               rd_en_q, rd_en_d;
  logic [WADDR_W-1:0] addr_q, addr_d;
  logic               wr_en_q, wr_en_d;
  logic [ROW_W-1:0]   wr_row_q, wr_row_d;
  logic               wr_sel_q, wr_sel_d;
  logic               rdy_q, rdy_d;
  logic               buffered_q, buffered_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef WEIGHT_FETCH_ERR_EN
  logic               err_q, err_d;
`endif

  logic [CNT_W-1:0]   occ;
  logic [CNT_W-1:0]   occ_nx;
  logic               consume;
  logic [TDIM_W-1:0]  tiles_x;
  logic [TDIM_W-1:0]  tiles_y;
  logic [AW1-1:0]     addr_full;

  // Next-state, counter and registered-output computation
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    total_d      = total_q;
    fetch_tile_d = fetch_tile_q;
    row_cnt_d    = row_cnt_q;
    done_d       = 1'b0;

    occ        = complete_q - consumed_q;
    consume    = next_weight_tile_i && (state_q != IDLE) && (occ != '0);
    complete_d = complete_q + CNT_W'(wr_en_q && (wr_row_q == ROW_LAST));
    consumed_d = consumed_q + CNT_W'(consume);
    tiles_x    = TDIM_W'(W_DIM_i >> ROW_W) + TDIM_W'(1);
    tiles_y    = TDIM_W'(H_DIM_i >> ROW_W) + TDIM_W'(1);

    case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d       = weight_start_addr_i;
          total_d      = CNT_W'(tiles_x) * CNT_W'(tiles_y);
          fetch_tile_d = '0;
          row_cnt_d    = '0;
          complete_d   = '0;
          consumed_d   = '0;
          state_d      = FETCH;
        end
      end
      FETCH: begin
        if (row_cnt_q == ROW_LAST) begin
          row_cnt_d    = '0;
          fetch_tile_d = fetch_tile_q + CNT_W'(1);
          if (fetch_tile_d == total_q) begin
            state_d = WAIT_DONE;
          end else if (CNT_W'(fetch_tile_d - consumed_d) >= CNT_W'(2)) begin
            state_d = WAIT_SLOT;
          end
        end else begin
          row_cnt_d = row_cnt_q + ROW_W'(1);
        end
      end
      WAIT_SLOT: begin
        if (CNT_W'(fetch_tile_q - consumed_d) < CNT_W'(2)) begin
          state_d = FETCH;
        end
      end
      WAIT_DONE: begin
        // Every tile is already written once the last one is consumed
        if ((consumed_d == total_q) && !rd_en_q && !wr_en_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    rd_en_d    = (state_d == FETCH);
    addr_full  = AW1'(base_d) + AW1'(fetch_tile_d) * AW1'(MUL_SIZE) + AW1'(row_cnt_d);
    addr_d     = rd_en_d ? addr_full[WADDR_W-1:0] : '0;
    wr_en_d    = rd_en_q;
    wr_row_d   = rd_en_q ? row_cnt_q : '0;
    wr_sel_d   = rd_en_q && fetch_tile_q[0];
    occ_nx     = complete_d - consumed_d;
    rdy_d      = (occ_nx != '0);
    buffered_d = (occ_nx == CNT_W'(2));
    busy_d     = (state_d != IDLE);

`ifdef WEIGHT_FETCH_ERR_EN
    err_d = err_q
          || (next_weight_tile_i && (occ == '0))
          || (start_i && busy_q)
          || (rd_en_d && addr_full[WADDR_W]);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      base_q       <= '0;
      total_q      <= '0;
      fetch_tile_q <= '0;
      row_cnt_q    <= '0;
      complete_q   <= '0;
      consumed_q   <= '0;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_row_q     <= '0;
      wr_sel_q     <= 1'b0;
      rdy_q        <= 1'b0;
      buffered_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef WEIGHT_FETCH_ERR_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      total_q      <= total_d;
      fetch_tile_q <= fetch_tile_d;
      row_cnt_q    <= row_cnt_d;
      complete_q   <= complete_d;
      consumed_q   <= consumed_d;
      rd_en_q      <= rd_en_d;
      addr_q       <= addr_d;
      wr_en_q      <= wr_en_d;
      wr_row_q     <= wr_row_d;
      wr_sel_q     <= wr_sel_d;
      rdy_q        <= rdy_d;
      buffered_q   <= buffered_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef WEIGHT_FETCH_ERR_EN
      err_q        <= err_d;
`endif
    end
  end

  assign weight_mem_rd_en_o         = rd_en_q;
  assign weight_mem_addr_o          = addr_q;
  assign weight_buf_wr_en_o         = wr_en_q;
  assign weight_buf_wr_row_o        = wr_row_q;
  assign weight_buf_wr_sel_o        = wr_sel_q;
  assign compute_weights_rdy_o      = rdy_q;
  assign compute_weights_buffered_o = buffered_q;
  assign busy_o                     = busy_q;
  assign done_o                     = done_q;
`ifdef WEIGHT_FETCH_ERR_EN
  assign err_o                      = err_q;
`endif

endmodule
